// File: rtl/gnt_ack_pkg.sv
// Shared constants and types for the grant/ack responder.
package gnt_ack_pkg;

  localparam int MAX_LAT  = 4;
  localparam int DEPTH    = 4;
  // Queue entries carry the widest supported tag; the top uses the low ID_W bits.
  localparam int ID_W_MAX = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [2:0]          stamp;
  } entry_t;

  // Modulo-8 age; the deadline keeps real ages at or below 4, so wrap is harmless.
  function automatic logic [2:0] age_of(input logic [2:0] now, input logic [2:0] stamp);
    return now - stamp;
  endfunction

endpackage

// File: rtl/gnt_ack_fifo.sv
// Four-entry circular buffer of pending grants; push and pop may share an edge.
module gnt_ack_fifo
  import gnt_ack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  entry_t     din,
  output entry_t     head,
  output logic [2:0] count,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 3'd0);

endmodule

// File: rtl/gnt_ack_responder.sv
// Acks each grant in order L cycles after it arrives; a stall may defer the ack
// but never past the 4-cycle deadline, where it is forced and flagged late.
module gnt_ack_responder
  import gnt_ack_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gnt,
  input  logic [ID_W-1:0]  gnt_id,
  input  logic [1:0]       lat_cfg,
  input  logic             stall,
  output logic             ack,
  output logic [ID_W-1:0]  ack_id,
  output logic             late,
  output logic [2:0]       outstanding,
  output logic [CNT_W-1:0] ack_cnt
);

  state_e     state;
  logic [2:0] now;
  logic [1:0] lat_cur;
  entry_t     head;
  entry_t     din;
  logic [2:0] count;
  logic       empty;
  logic [2:0] age;
  logic       eligible;
  logic       deadline;
  logic       pop;
  logic       unused_id_hi;

  assign din          = '{id: ID_W_MAX'(gnt_id), stamp: now};
  assign age          = age_of(now, head.stamp);
  assign eligible     = !empty && (age > {1'b0, lat_cur});
  assign deadline     = !empty && (age >= 3'(MAX_LAT));
  assign pop          = eligible && (!stall || deadline);
  assign unused_id_hi = ^head.id;

  gnt_ack_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      now     <= '0;
      lat_cur <= lat_cfg;
      ack     <= 1'b0;
      ack_id  <= '0;
      late    <= 1'b0;
      ack_cnt <= '0;
    end else begin
      now    <= now + 3'd1;
      ack    <= pop;
      ack_id <= pop ? head.id[ID_W-1:0] : '0;
      // A pop under stall can only be the forced deadline ack.
      late   <= pop && stall;
      if (pop) ack_cnt <= ack_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (gnt) state   <= BUSY;
          else     lat_cur <= lat_cfg;
        end
        BUSY: begin
          if (pop && count == 3'd1 && !gnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_gnt_ack_responder.sv
// Bench for gnt_ack_responder: vector table, directed corner sequences, random
// traffic, with a cycle model plus an ack scoreboard.
module tb_gnt_ack_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gnt = 1'b0;
  logic [3:0]  gnt_id = '0;
  logic [1:0]  lat_cfg = '0;
  logic        stall = 1'b0;
  logic        ack;
  logic [3:0]  ack_id;
  logic        late;
  logic [2:0]  outstanding;
  logic [15:0] ack_cnt;

  gnt_ack_responder #(.ID_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .lat_cfg     (lat_cfg),
    .stall       (stall),
    .ack         (ack),
    .ack_id      (ack_id),
    .late        (late),
    .outstanding (outstanding),
    .ack_cnt     (ack_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    int         t0;
  } exp_t;

  typedef struct {
    logic       r, g;
    logic [3:0] id;
    logic [1:0] lat;
    logic       st;
    logic       a;
    logic [3:0] aid;
    logic       lt;
    logic [2:0] out;
    int         cnt;
  } vec_t;

  exp_t mq[$];   // model queue
  exp_t dq[$];   // scoreboard, popped on DUT acks
  int   e = 0;
  int   mlat = 0;
  int   e_ack, e_id, e_late, e_cnt;
  int   total = 0, bad = 0;
  logic miss = 1'b0;
  vec_t tbl [18];

  assert property (@(posedge clk) disable iff (!rst_n) !miss);
  assert property (@(posedge clk) !ack |-> (ack_id == 4'd0 && !late));
  cover property (@(posedge clk) ack && dut.lat_cur == 2'd0);
  cover property (@(posedge clk) ack && dut.lat_cur == 2'd1);
  cover property (@(posedge clk) ack && dut.lat_cur == 2'd2);
  cover property (@(posedge clk) ack && dut.lat_cur == 2'd3);
  cover property (@(posedge clk) ack && late);

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, e, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic g, input logic [3:0] id,
                     input logic [1:0] lat, input logic st);
    bit   was_empty;
    int   age;
    exp_t x;
    rst_n = r; gnt = g; gnt_id = id; lat_cfg = lat; stall = st;
    e++;
    if (!r) begin
      mq.delete(); dq.delete();
      mlat = lat; e_ack = 0; e_id = 0; e_late = 0; e_cnt = 0;
    end else begin
      was_empty = (mq.size() == 0);
      e_ack = 0; e_id = 0; e_late = 0;
      if (!was_empty) begin
        age = e - mq[0].t0;
        if (age > mlat && (!st || age >= 4)) begin
          x = mq.pop_front();
          e_ack = 1; e_id = x.id; e_late = st;
        end
      end
      if (g) begin
        mq.push_back('{id, e});
        dq.push_back('{id, e});
      end
      if (was_empty && !g) mlat = lat;
      e_cnt = (e_cnt + e_ack) & 32'hFFFF;
    end
    @(posedge clk);
    @(negedge clk);
    check("ack", ack, e_ack);
    check("ack_id", ack_id, e_id);
    check("late", late, e_late);
    check("outstanding", outstanding, mq.size());
    check("ack_cnt", ack_cnt, e_cnt);
    if (ack) begin
      if (dq.size() == 0) check("spurious_ack", 1, 0);
      else begin
        x = dq.pop_front();
        check("sb_id", ack_id, x.id);
        check("sb_window", (e - x.t0 >= 1 && e - x.t0 <= 4) ? 1 : 0, 1);
      end
    end
    miss = (dq.size() > 0) && (e - dq[0].t0 >= 4);
    check("deadline", miss, 0);
  endtask

  initial begin
    int peak, n, seen;

    //        r  g  id  lat st | a aid lt out cnt
    tbl[0]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 5,  0, 0,  0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 0,  0, 0,  1, 5, 0, 0, 1};
    tbl[4]  = '{1, 0, 0,  1, 0,  0, 0, 0, 0, 1};
    tbl[5]  = '{1, 1, 9,  1, 1,  0, 0, 0, 1, 1};
    tbl[6]  = '{1, 0, 0,  1, 1,  0, 0, 0, 1, 1};
    tbl[7]  = '{1, 0, 0,  1, 1,  0, 0, 0, 1, 1};
    tbl[8]  = '{1, 0, 0,  1, 1,  0, 0, 0, 1, 1};
    tbl[9]  = '{1, 0, 0,  1, 1,  1, 9, 1, 0, 2};
    tbl[10] = '{1, 0, 0,  1, 0,  0, 0, 0, 0, 2};
    tbl[11] = '{1, 1, 3,  1, 0,  0, 0, 0, 1, 2};
    tbl[12] = '{1, 0, 0,  1, 0,  0, 0, 0, 1, 2};
    tbl[13] = '{1, 0, 0,  1, 0,  1, 3, 0, 0, 3};
    tbl[14] = '{1, 1, 6,  2, 0,  0, 0, 0, 1, 3};
    tbl[15] = '{1, 0, 0,  2, 1,  0, 0, 0, 1, 3};
    tbl[16] = '{1, 0, 0,  2, 1,  0, 0, 0, 1, 3};
    tbl[17] = '{1, 0, 0,  2, 0,  1, 6, 0, 0, 4};

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, tbl[i].g, tbl[i].id, tbl[i].lat, tbl[i].st);
      check("tbl_ack", ack, tbl[i].a);
      check("tbl_id", ack_id, tbl[i].aid);
      check("tbl_late", late, tbl[i].lt);
      check("tbl_out", outstanding, tbl[i].out);
      check("tbl_cnt", ack_cnt, tbl[i].cnt);
    end

    // back-to-back grants at L=4
    cyc(1, 0, 0, 3, 0);
    peak = 0; n = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, (i < 8), 4'(i), 3, 0);
      if (int'(outstanding) > peak) peak = outstanding;
      if (ack) n++;
    end
    check("b2b_peak", peak, 4);
    check("b2b_acks", n, 8);

    // lat_cfg change while busy is held off until the next idle edge
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 3, 0);
    cyc(1, 1, 2, 3, 0);
    check("busy_lat_first", ack_id, 1);
    cyc(1, 0, 0, 3, 0);
    check("busy_lat_second", ack_id, 2);
    cyc(1, 0, 0, 3, 0);
    cyc(1, 1, 4, 3, 0);
    seen = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 0, 3, 0);
      if (ack && seen == 0) seen = k;
    end
    check("lat_after_idle", seen, 4);

    // reset discards a pending grant; grants during reset are ignored
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_all_zero", (ack | late | (ack_id != 0) | (outstanding != 0) | (ack_cnt != 0)) ? 1 : 0, 0);
    cyc(0, 1, 5, 0, 0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (ack) n++;
    end
    check("no_ack_after_rst", n, 0);

    // random traffic with stalls and latency changes
    for (int k = 0; k < 400; k++)
      cyc(1, 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 0);

    // ack counter wrap
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) cyc(1, 1, 4'(i), 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("cnt_full", ack_cnt, 65535);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("cnt_wrap_ack", ack, 1);
    check("cnt_wrap", ack_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
